// File: rtl/sync_arbiter_if.sv
// Requester-side bundle for sync_arbiter: window, per-channel requests and arbiter results.
// Latency: none (wires only).
// Backpressure: none; requesters hold pending until they observe done.
// Ports: enabled, pending[CHANNELS] (requester -> arbiter);
//        strobe, done[CHANNELS], grant_idx, busy (arbiter -> requester).
interface sync_arbiter_if #(
    parameter int CHANNELS = 4
);
    localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                enabled;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] strobe;
    logic [CHANNELS-1:0] done;
    logic [IDXW-1:0]     grant_idx;
    logic                busy;

    modport master (
        output enabled,
        output pending,
        input  strobe,
        input  done,
        input  grant_idx,
        input  busy
    );

    modport slave (
        input  enabled,
        input  pending,
        output strobe,
        output done,
        output grant_idx,
        output busy
    );
endinterface

// File: rtl/sync_arbiter.sv
// Grants at most one ARMED requester per bus window; strobe in the window's first cycle.
// Latency: pending (window closed) -> ARMED next edge; strobe in next window; done after strobe edge.
// Backpressure: losers stay ARMED and retry next window; pending held until done seen.
// Ports: clk, reset_n (async, active-low); bus (slave modport of sync_arbiter_if).
module sync_arbiter #(
    parameter int CHANNELS      = 4,
    parameter int PRIORITY_MODE = 0
) (
    input  logic           clk,
    input  logic           reset_n,
    sync_arbiter_if.slave  bus
);
    localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]          r_state [CHANNELS];
    logic [IDXW-1:0]     r_ptr;
    logic [IDXW-1:0]     r_grant_idx;
    logic                r_window_used;

    logic [CHANNELS-1:0] w_armed;
    logic [CHANNELS-1:0] w_done;
    logic [CHANNELS-1:0] w_strobe;
    logic [IDXW-1:0]     w_grant;
    logic                w_grant_valid;
    logic                w_fire;

    always_comb begin
        w_armed = '0;
        w_done  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_armed[i] = (r_state[i] == ST_ARMED);
            w_done[i]  = (r_state[i] == ST_DONE) && bus.pending[i];
        end
    end

    // The ARMED vector only changes while enabled=0 (arming) or on a strobe edge,
    // so the winner is stable for the whole strobe cycle.
    always_comb begin
        int  v_idx;
        logic v_found;
        v_idx   = 0;
        v_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (PRIORITY_MODE == 1) begin
                v_idx = k;
            end else begin
                v_idx = (int'(r_ptr) + k) % CHANNELS;
            end
            if (!v_found && w_armed[v_idx]) begin
                v_found = 1'b1;
                w_grant = IDXW'(v_idx);
            end
        end
    end

    assign w_grant_valid = |w_armed;

    // Qualifying with pending lets a requester withdraw during its strobe cycle;
    // the window then stays unconsumed because no strobe bit is seen at the edge.
    always_comb begin
        w_strobe = '0;
        if (bus.enabled && w_grant_valid && !r_window_used && bus.pending[w_grant]) begin
            w_strobe[w_grant] = 1'b1;
        end
    end

    assign w_fire = |w_strobe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!bus.pending[i]) begin
                    r_state[i] <= ST_IDLE;
                end else begin
                    case (r_state[i])
                        // Arming only outside a window keeps late requests out of it.
                        ST_IDLE:  if (!bus.enabled) r_state[i] <= ST_ARMED;
                        ST_ARMED: if (w_strobe[i])  r_state[i] <= ST_DONE;
                        ST_DONE:  r_state[i] <= ST_DONE;
                        default:  r_state[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_window_used <= 1'b0;
            r_ptr         <= '0;
            r_grant_idx   <= '0;
        end else begin
            if (!bus.enabled) begin
                r_window_used <= 1'b0;
            end else if (w_fire) begin
                r_window_used <= 1'b1;
            end
            if (w_fire) begin
                r_grant_idx <= w_grant;
                if (w_grant == IDXW'(CHANNELS - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_grant + 1'b1;
                end
            end
        end
    end

    assign bus.strobe    = w_strobe;
    assign bus.done      = w_done;
    assign bus.grant_idx = r_grant_idx;
    assign bus.busy      = |w_armed;

endmodule

// File: tb/tb_sync_arbiter.sv
// Directed bench for sync_arbiter: round-robin and fixed-priority instances side by side.
// Latency: n/a.
// Backpressure: n/a.
module tb_sync_arbiter;
    logic clk;
    logic reset_n;
    int   tests;
    int   errors;

    sync_arbiter_if #(.CHANNELS(4)) ifr ();
    sync_arbiter_if #(.CHANNELS(4)) ifp ();

    sync_arbiter #(.CHANNELS(4), .PRIORITY_MODE(0)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifr.slave)
    );

    sync_arbiter #(.CHANNELS(4), .PRIORITY_MODE(1)) u_pr (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ifr.enabled = 1'b0;
        ifr.pending = '0;
        ifp.enabled = 1'b0;
        ifp.pending = '0;
        reset_n     = 1'b0;
        #2;
        reset_n     = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        ifr.enabled = 1'b0;
        ifr.pending = '0;
        ifp.enabled = 1'b0;
        ifp.pending = '0;
        reset_n     = 1'b0;
        #12;
        tests++;
        if (ifr.strobe !== 4'b0000) begin
            $display("FAIL reset_strobe: got %b want 0000", ifr.strobe); errors++;
        end
        tests++;
        if (ifr.done !== 4'b0000) begin
            $display("FAIL reset_done: got %b want 0000", ifr.done); errors++;
        end
        tests++;
        if (ifr.busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b want 0", ifr.busy); errors++;
        end
        tests++;
        if (ifr.grant_idx !== 2'd0) begin
            $display("FAIL reset_grant_idx: got %0d want 0", ifr.grant_idx); errors++;
        end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        do_reset();
        ifr.pending = 4'b0100;
        cyc();
        tests++;
        if (ifr.busy !== 1'b1) begin
            $display("FAIL single_armed_busy: got %b want 1", ifr.busy); errors++;
        end
        ifr.enabled = 1'b1;
        #1;
        tests++;
        if (ifr.strobe !== 4'b0100) begin
            $display("FAIL single_strobe: got %b want 0100", ifr.strobe); errors++;
        end
        cyc();
        tests++;
        if (ifr.strobe !== 4'b0000) begin
            $display("FAIL single_strobe_cycle2: got %b want 0000", ifr.strobe); errors++;
        end
        tests++;
        if (ifr.done !== 4'b0100) begin
            $display("FAIL single_done: got %b want 0100", ifr.done); errors++;
        end
        tests++;
        if (ifr.grant_idx !== 2'd2) begin
            $display("FAIL single_grant_idx: got %0d want 2", ifr.grant_idx); errors++;
        end
        tests++;
        if (ifr.busy !== 1'b0) begin
            $display("FAIL single_busy_after: got %b want 0", ifr.busy); errors++;
        end
        cyc();
        tests++;
        if (ifr.strobe !== 4'b0000) begin
            $display("FAIL single_strobe_cycle3: got %b want 0000", ifr.strobe); errors++;
        end
        ifr.enabled = 1'b0;
        cyc();
        ifr.pending = 4'b0000;
        #1;
        tests++;
        if (ifr.done !== 4'b0000) begin
            $display("FAIL single_done_drop: got %b want 0000", ifr.done); errors++;
        end
        cyc();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_done;
        do_reset();
        ifr.pending = 4'b1111;
        cyc();
        exp_done = 4'b0000;
        for (int w = 0; w < 4; w++) begin
            ifr.enabled = 1'b1;
            #1;
            tests++;
            if (ifr.strobe !== (4'b0001 << w)) begin
                $display("FAIL rr_strobe_w%0d: got %b want %b", w, ifr.strobe, 4'b0001 << w);
                errors++;
            end
            cyc();
            exp_done[w] = 1'b1;
            tests++;
            if (ifr.done !== exp_done) begin
                $display("FAIL rr_done_w%0d: got %b want %b", w, ifr.done, exp_done); errors++;
            end
            tests++;
            if (ifr.grant_idx !== 2'(w)) begin
                $display("FAIL rr_grant_idx_w%0d: got %0d want %0d", w, ifr.grant_idx, w);
                errors++;
            end
            ifr.enabled = 1'b0;
            cyc();
        end
        ifr.enabled = 1'b1;
        #1;
        tests++;
        if (ifr.strobe !== 4'b0000) begin
            $display("FAIL rr_fifth_window_strobe: got %b want 0000", ifr.strobe); errors++;
        end
        tests++;
        if (ifr.busy !== 1'b0) begin
            $display("FAIL rr_busy_end: got %b want 0", ifr.busy); errors++;
        end
        cyc();
        ifr.enabled = 1'b0;
        ifr.pending = 4'b0000;
        cyc();
    endtask

    task automatic test_priority();
        do_reset();
        ifp.pending = 4'b1111;
        cyc();
        ifp.enabled = 1'b1;
        #1;
        tests++;
        if (ifp.strobe !== 4'b0001) begin
            $display("FAIL prio_strobe_w0: got %b want 0001", ifp.strobe); errors++;
        end
        cyc();
        ifp.enabled = 1'b0;
        ifp.pending = 4'b1110;
        cyc();
        ifp.enabled = 1'b1;
        #1;
        tests++;
        if (ifp.strobe !== 4'b0010) begin
            $display("FAIL prio_strobe_w1: got %b want 0010", ifp.strobe); errors++;
        end
        cyc();
        ifp.enabled = 1'b0;
        ifp.pending = 4'b1111;
        cyc();
        ifp.enabled = 1'b1;
        #1;
        tests++;
        if (ifp.strobe !== 4'b0001) begin
            $display("FAIL prio_rearm_wins: got %b want 0001", ifp.strobe); errors++;
        end
        cyc();
        tests++;
        if (ifp.done !== 4'b0011) begin
            $display("FAIL prio_done: got %b want 0011", ifp.done); errors++;
        end
        tests++;
        if (ifp.grant_idx !== 2'd0) begin
            $display("FAIL prio_grant_idx: got %0d want 0", ifp.grant_idx); errors++;
        end
        ifp.enabled = 1'b0;
        cyc();
        ifp.enabled = 1'b1;
        #1;
        tests++;
        if (ifp.strobe !== 4'b0100) begin
            $display("FAIL prio_strobe_w3: got %b want 0100", ifp.strobe); errors++;
        end
        cyc();
        ifp.enabled = 1'b0;
        ifp.pending = 4'b0000;
        cyc();
    endtask

    task automatic test_late_request();
        do_reset();
        ifr.enabled = 1'b1;
        #1;
        ifr.pending = 4'b0010;
        #1;
        tests++;
        if (ifr.strobe !== 4'b0000) begin
            $display("FAIL late_strobe_same_window: got %b want 0000", ifr.strobe); errors++;
        end
        cyc();
        tests++;
        if (ifr.busy !== 1'b0) begin
            $display("FAIL late_not_armed: got %b want 0", ifr.busy); errors++;
        end
        tests++;
        if (ifr.strobe !== 4'b0000) begin
            $display("FAIL late_strobe_cycle2: got %b want 0000", ifr.strobe); errors++;
        end
        ifr.enabled = 1'b0;
        cyc();
        ifr.enabled = 1'b1;
        #1;
        tests++;
        if (ifr.strobe !== 4'b0010) begin
            $display("FAIL late_strobe_next_window: got %b want 0010", ifr.strobe); errors++;
        end
        cyc();
        ifr.enabled = 1'b0;
        ifr.pending = 4'b0000;
        cyc();
    endtask

    task automatic test_drop_during_strobe();
        do_reset();
        ifr.pending = 4'b1000;
        cyc();
        ifr.enabled = 1'b1;
        #1;
        tests++;
        if (ifr.strobe !== 4'b1000) begin
            $display("FAIL drop_strobe_before: got %b want 1000", ifr.strobe); errors++;
        end
        ifr.pending = 4'b0000;
        #1;
        tests++;
        if (ifr.strobe !== 4'b0000) begin
            $display("FAIL drop_strobe_after: got %b want 0000", ifr.strobe); errors++;
        end
        cyc();
        tests++;
        if (ifr.done !== 4'b0000) begin
            $display("FAIL drop_done: got %b want 0000", ifr.done); errors++;
        end
        tests++;
        if (ifr.busy !== 1'b0) begin
            $display("FAIL drop_state_idle: got %b want 0", ifr.busy); errors++;
        end
        tests++;
        if (ifr.grant_idx !== 2'd0) begin
            $display("FAIL drop_grant_idx: got %0d want 0", ifr.grant_idx); errors++;
        end
        ifr.enabled = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_window();
        do_reset();
        ifr.pending = 4'b0010;
        cyc();
        ifr.enabled = 1'b1;
        #1;
        tests++;
        if (ifr.strobe !== 4'b0010) begin
            $display("FAIL rstmid_strobe_before: got %b want 0010", ifr.strobe); errors++;
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (ifr.strobe !== 4'b0000) begin
            $display("FAIL rstmid_strobe: got %b want 0000", ifr.strobe); errors++;
        end
        tests++;
        if (ifr.busy !== 1'b0) begin
            $display("FAIL rstmid_busy: got %b want 0", ifr.busy); errors++;
        end
        tests++;
        if (ifr.done !== 4'b0000) begin
            $display("FAIL rstmid_done: got %b want 0000", ifr.done); errors++;
        end
        ifr.enabled = 1'b0;
        reset_n     = 1'b1;
        cyc();
        tests++;
        if (ifr.busy !== 1'b1) begin
            $display("FAIL rstmid_rearmed: got %b want 1", ifr.busy); errors++;
        end
        ifr.enabled = 1'b1;
        #1;
        tests++;
        if (ifr.strobe !== 4'b0010) begin
            $display("FAIL rstmid_strobe_next: got %b want 0010", ifr.strobe); errors++;
        end
        cyc();
        tests++;
        if (ifr.done !== 4'b0010) begin
            $display("FAIL rstmid_done_next: got %b want 0010", ifr.done); errors++;
        end
        ifr.enabled = 1'b0;
        ifr.pending = 4'b0000;
        cyc();
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_late_request();
        test_drop_during_strobe();
        test_reset_mid_window();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
